bram_capture_ctrl: RTL

- Sequences radar-receiver sample capture into a two-bank (ping-pong) BRAM region shared with the PS.
- Arms on a software start command and begins each acquisition on a pulse trigger.
- Writes N_SAMPLES 32-bit words per acquisition, flags the filled bank to the PS, then switches banks.
- Sits between the ADC/decimator stream and the BRAM port A; the PS reads and acknowledges banks through port B.

---
 rtl/bram_capture_pkg.sv | 20 ++
 rtl/bram_capture_if.sv | 23 ++
 rtl/bram_capture_addr_gen.sv | 74 +++++++
 rtl/bram_capture_ctrl.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/bram_capture_pkg.sv
// Shared state type and constants for the ping-pong BRAM capture controller.
// Building with CAPTURE_TIMESTAMP_EN defined puts a one-word trigger timestamp header at the start of each bank.
package bram_capture_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    localparam int WORD_BYTES = 4;
    localparam int NUM_BANKS  = 2;

`ifdef CAPTURE_TIMESTAMP_EN
    localparam int HDR_WORDS = 1;
`else
    localparam int HDR_WORDS = 0;
`endif

endpackage

// File: rtl/bram_capture_if.sv
// Sample stream in and BRAM port A out, as seen by the capture controller (master)
// and by the surrounding ADC/BRAM fabric (slave).
interface bram_capture_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              bram_en;
    logic [3:0]        bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_din;

    modport master (
        input  s_valid, s_data,
        output bram_en, bram_we, bram_addr, bram_din
    );

    modport slave (
        output s_valid, s_data,
        input  bram_en, bram_we, bram_addr, bram_din
    );
endinterface

// File: rtl/bram_capture_addr_gen.sv
// Word index counter and registered BRAM port A write stage for one capture bank.
// clear restarts the bank (and issues the header word when headers are built in); advance writes one sample.
module bram_capture_addr_gen
    import bram_capture_pkg::*;
#(
    parameter int N_SAMPLES  = 2048,
    parameter int BANK_BYTES = 8192,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              advance,
    input  logic              bank,
    input  logic [DATA_W-1:0] hdr_data,
    input  logic [DATA_W-1:0] sample,
    output logic              full,
    output logic              en,
    output logic [3:0]        we,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] din
);

    localparam logic [ADDR_W-1:0] IDX_FIRST = ADDR_W'(HDR_WORDS);
    localparam logic [ADDR_W-1:0] IDX_END   = ADDR_W'(N_SAMPLES + HDR_WORDS);
    localparam logic [ADDR_W-1:0] BANK_SPAN = ADDR_W'(BANK_BYTES);
    localparam logic [ADDR_W-1:0] WORD_SPAN = ADDR_W'(WORD_BYTES);

    logic [ADDR_W-1:0] idx_p0;
    logic [ADDR_W-1:0] base;
    logic              en_p0;
    logic [3:0]        we_p0;
    logic [ADDR_W-1:0] addr_p0;
    logic [DATA_W-1:0] din_p0;

    assign base = bank ? BANK_SPAN : '0;
    assign full = (idx_p0 == IDX_END);

    // p0: one registered write per clear (header) or advance (sample)
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_p0  <= '0;
            en_p0   <= 1'b0;
            we_p0   <= 4'h0;
            addr_p0 <= '0;
            din_p0  <= '0;
        end else begin
            en_p0 <= 1'b0;
            we_p0 <= 4'h0;
            if (clear) begin
                idx_p0 <= IDX_FIRST;
                if (HDR_WORDS != 0) begin
                    en_p0   <= 1'b1;
                    we_p0   <= 4'hF;
                    addr_p0 <= base;
                    din_p0  <= hdr_data;
                end
            end else if (advance) begin
                idx_p0  <= idx_p0 + ADDR_W'(1);
                en_p0   <= 1'b1;
                we_p0   <= 4'hF;
                addr_p0 <= base + idx_p0 * WORD_SPAN;
                din_p0  <= sample;
            end
        end
    end

    assign en   = en_p0;
    assign we   = we_p0;
    assign addr = addr_p0;
    assign din  = din_p0;

endmodule

// File: rtl/bram_capture_ctrl.sv
// Ping-pong BRAM capture sequencer: arm on start, capture N_SAMPLES words per trigger edge, flag bank, swap.
// Define CAPTURE_TIMESTAMP_EN to prepend the free-running cycle count at the trigger as header word 0.
module bram_capture_ctrl
    import bram_capture_pkg::*;
#(
    parameter int N_SAMPLES  = 2048,
    parameter int BANK_BYTES = 8192,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 trig,
    input  logic [NUM_BANKS-1:0] bank_ack,
    bram_capture_if.master       bus,
    output logic [NUM_BANKS-1:0] bank_rdy,
    output logic                 cur_bank,
    output logic                 busy,
    output logic                 overflow,
    output logic                 irq
);

    state_t              state, state_nx;
    logic                trig_d;
    logic                trig_rise;
    logic                clear, advance, done;
    logic                ovf_set, ovf_clr;
    logic                full;
    logic [DATA_W-1:0]   hdr_data;
    logic [NUM_BANKS-1:0] bank_set;

    assign trig_rise = trig & ~trig_d;

`ifdef CAPTURE_TIMESTAMP_EN
    logic [31:0] ts_cnt;

    always_ff @(posedge clk) begin
        if (rst) ts_cnt <= '0;
        else     ts_cnt <= ts_cnt + 32'd1;
    end

    assign hdr_data = DATA_W'(ts_cnt);
`else
    assign hdr_data = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // stop overrides every other action, including a completion due this cycle
    always_comb begin
        state_nx = state;
        clear    = 1'b0;
        advance  = 1'b0;
        done     = 1'b0;
        ovf_set  = 1'b0;
        ovf_clr  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = ARMED;
                    ovf_clr  = 1'b1;
                end
            end
            ARMED: begin
                if (trig_rise) begin
                    if (bank_rdy[cur_bank]) begin
                        ovf_set = 1'b1;
                    end else begin
                        state_nx = CAPTURE;
                        clear    = 1'b1;
                    end
                end
            end
            CAPTURE: begin
                if (full) begin
                    state_nx = ARMED;
                    done     = 1'b1;
                end else begin
                    advance = bus.s_valid;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (stop) begin
            state_nx = IDLE;
            clear    = 1'b0;
            advance  = 1'b0;
            done     = 1'b0;
            ovf_set  = 1'b0;
            ovf_clr  = 1'b0;
        end
    end

    assign bank_set = done ? (NUM_BANKS'(1) << cur_bank) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            trig_d   <= 1'b0;
            cur_bank <= 1'b0;
            bank_rdy <= '0;
            overflow <= 1'b0;
            irq      <= 1'b0;
        end else begin
            trig_d   <= trig;
            irq      <= done;
            bank_rdy <= (bank_rdy & ~bank_ack) | bank_set;
            if (done)         cur_bank <= ~cur_bank;
            if (ovf_clr)      overflow <= 1'b0;
            else if (ovf_set) overflow <= 1'b1;
        end
    end

    assign busy = (state == CAPTURE);

    bram_capture_addr_gen #(
        .N_SAMPLES (N_SAMPLES),
        .BANK_BYTES(BANK_BYTES),
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W)
    ) u_addr_gen (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .advance (advance),
        .bank    (cur_bank),
        .hdr_data(hdr_data),
        .sample  (bus.s_data),
        .full    (full),
        .en      (bus.bram_en),
        .we      (bus.bram_we),
        .addr    (bus.bram_addr),
        .din     (bus.bram_din)
    );

endmodule
